pipelined_fp_addsub: RTL and testbench

PIPELINED_FP_ADDSUB -- requirements
Module: pipelined_fp_addsub

---
 rtl/pipelined_fp_addsub.sv | 237 +++++++++++++++++++++++
 tb/tb_pipelined_fp_addsub.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_fp_addsub.sv
// Four-stage pipelined floating-point adder/subtractor with sideband tag.
// Stages: unpack/compare/special-detect, align with G/R/S, add/sub, normalise/round/pack.
// Subnormals are treated as zero on input and flushed to zero on output.
module pipelined_fp_addsub #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   op,
  input  logic [TAG_W-1:0]       tag_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [TAG_W-1:0]       tag_out,
  output logic [2:0]             flags
);

  localparam int unsigned W        = 1 + EXP_W + MAN_W;
  localparam int unsigned ExtW     = MAN_W + 4;     // hidden + fraction + guard/round/sticky
  localparam int unsigned NormW    = ExtW - 1;      // normalised value without hidden bit
  localparam int unsigned ExpCalcW = EXP_W + 2;     // room for carry and negative exponents
  localparam int unsigned LzW      = $clog2(ExtW + 1);
  localparam int unsigned MaxShift = MAN_W + 3;
  localparam logic [EXP_W-1:0] ExpMax = '1;
  localparam logic [W-1:0] QNan = {1'b0, ExpMax, 1'b1, {(MAN_W - 1){1'b0}}};

  // Global stall: the whole pipe moves only when the output slot is free or being drained.
  assign in_ready = !out_valid || out_ready;

  // ---------------- Stage 1: unpack, compare, special detect ----------------
  logic             a_sign, b_sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic             a_snan, b_snan, a_big;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic [MAN_W:0]   a_man, b_man;
  logic [W-2:0]     a_mag, b_mag;
  logic             c1_spec;
  logic [W-1:0]     c1_spec_res;
  logic [2:0]       c1_spec_flags;

  logic             s1_valid, s1_spec, s1_sign, s1_eff_sub;
  logic [W-1:0]     s1_spec_res;
  logic [2:0]       s1_spec_flags;
  logic [TAG_W-1:0] s1_tag;
  logic [EXP_W-1:0] s1_exp, s1_diff;
  logic [MAN_W:0]   s1_man_l, s1_man_s;

  // Decode operands (B sign folded with op) and pick the larger magnitude.
  always_comb begin
    a_sign = a[W-1];
    a_exp  = a[W-2:MAN_W];
    a_frac = a[MAN_W-1:0];
    b_sign = b[W-1] ^ op;
    b_exp  = b[W-2:MAN_W];
    b_frac = b[MAN_W-1:0];
    a_zero = (a_exp == '0);
    b_zero = (b_exp == '0);
    a_nan  = (a_exp == ExpMax) && (a_frac != '0);
    b_nan  = (b_exp == ExpMax) && (b_frac != '0);
    a_inf  = (a_exp == ExpMax) && (a_frac == '0);
    b_inf  = (b_exp == ExpMax) && (b_frac == '0);
    a_snan = a_nan && !a_frac[MAN_W-1];
    b_snan = b_nan && !b_frac[MAN_W-1];
    a_man  = a_zero ? '0 : {1'b1, a_frac};
    b_man  = b_zero ? '0 : {1'b1, b_frac};
    a_mag  = a_zero ? '0 : {a_exp, a_frac};
    b_mag  = b_zero ? '0 : {b_exp, b_frac};
    a_big  = (a_mag >= b_mag);

    c1_spec       = 1'b0;
    c1_spec_res   = '0;
    c1_spec_flags = '0;
    if (a_nan || b_nan) begin
      c1_spec       = 1'b1;
      c1_spec_res   = QNan;
      c1_spec_flags = {a_snan || b_snan, 2'b00};
    end else if (a_inf && b_inf && (a_sign ^ b_sign)) begin
      c1_spec       = 1'b1;
      c1_spec_res   = QNan;
      c1_spec_flags = 3'b100;
    end else if (a_inf) begin
      c1_spec     = 1'b1;
      c1_spec_res = {a_sign, ExpMax, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      c1_spec     = 1'b1;
      c1_spec_res = {b_sign, ExpMax, {MAN_W{1'b0}}};
    end
  end

  // ---------------- Stage 2: align smaller operand ----------------
  logic [EXP_W-1:0] shamt;
  logic [ExtW-1:0]  small_ext, lost, c2_aligned;

  logic             s2_valid, s2_spec, s2_sign, s2_eff_sub;
  logic [W-1:0]     s2_spec_res;
  logic [2:0]       s2_spec_flags;
  logic [TAG_W-1:0] s2_tag;
  logic [EXP_W-1:0] s2_exp;
  logic [ExtW-1:0]  s2_man_l, s2_man_s;

  // Saturating right shift; every bit shifted out is folded into the sticky LSB.
  always_comb begin
    shamt      = (32'(s1_diff) > MaxShift) ? EXP_W'(MaxShift) : s1_diff;
    small_ext  = {s1_man_s, 3'b000};
    lost       = small_ext & ~({ExtW{1'b1}} << shamt);
    c2_aligned = (small_ext >> shamt) | ExtW'(|lost);
  end

  // ---------------- Stage 3: add / subtract ----------------
  logic [ExtW:0]    c3_sum;

  logic             s3_valid, s3_spec, s3_sign, s3_eff_sub;
  logic [W-1:0]     s3_spec_res;
  logic [2:0]       s3_spec_flags;
  logic [TAG_W-1:0] s3_tag;
  logic [EXP_W-1:0] s3_exp;
  logic [ExtW:0]    s3_sum;

  // Larger magnitude is always the minuend, so the difference is never negative.
  always_comb begin
    c3_sum = s2_eff_sub ? ({1'b0, s2_man_l} - {1'b0, s2_man_s})
                        : ({1'b0, s2_man_l} + {1'b0, s2_man_s});
  end

  // ---------------- Stage 4: normalise, round, pack ----------------
  logic [LzW-1:0]      lz;
  logic                lz_found, rnd;
  logic [NormW-1:0]    norm;
  logic [MAN_W:0]      frac_r;
  logic [ExpCalcW-1:0] e_pre, e_fin;
  logic [W-1:0]        c4_res;
  logic [2:0]          c4_flags;

  // Leading-zero count, normalise, round-to-nearest-even, then range checks.
  always_comb begin
    lz       = '0;
    lz_found = 1'b0;
    for (int i = ExtW - 1; i >= 0; i--) begin
      if (!lz_found && s3_sum[i]) begin
        lz       = LzW'(ExtW - 1 - i);
        lz_found = 1'b1;
      end
    end

    if (s3_sum[ExtW]) begin
      norm  = {s3_sum[ExtW-1:2], s3_sum[1] | s3_sum[0]};
      e_pre = ExpCalcW'(s3_exp) + ExpCalcW'(1);
    end else begin
      norm  = NormW'(s3_sum[ExtW-1:0] << lz);
      e_pre = ExpCalcW'(s3_exp) - ExpCalcW'(lz);
    end

    rnd    = norm[2] & (norm[1] | norm[0] | norm[3]);
    frac_r = {1'b0, norm[NormW-1:3]} + (MAN_W + 1)'(rnd);
    // A fraction carry-out means the mantissa rounded up to the next power of two.
    e_fin  = e_pre + ExpCalcW'(frac_r[MAN_W]);

    c4_res   = {s3_sign, e_fin[EXP_W-1:0], frac_r[MAN_W-1:0]};
    c4_flags = {2'b00, |norm[2:0]};
    if (s3_sum == '0) begin
      // Exact zero: only (-0)+(-0) keeps a negative sign.
      c4_res   = {s3_sign & ~s3_eff_sub, {(W - 1){1'b0}}};
      c4_flags = 3'b000;
    end else if (e_pre[ExpCalcW-1] || (e_pre == '0)) begin
      c4_res   = {s3_sign, {(W - 1){1'b0}}};
      c4_flags = 3'b001;
    end else if (e_fin >= ExpCalcW'(ExpMax)) begin
      c4_res   = {s3_sign, ExpMax, {MAN_W{1'b0}}};
      c4_flags = 3'b011;
    end
  end

  // Valid bits and output registers: reset clears them, stall holds them.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      tag_out   <= '0;
      flags     <= '0;
    end else if (in_ready) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      s3_valid  <= s2_valid;
      out_valid <= s3_valid;
      if (s3_valid) begin
        result  <= s3_spec ? s3_spec_res : c4_res;
        flags   <= s3_spec ? s3_spec_flags : c4_flags;
        tag_out <= s3_tag;
      end
    end
  end

  // Stage payloads advance with the pipe; their meaning is qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (in_ready) begin
      s1_tag        <= tag_in;
      s1_spec       <= c1_spec;
      s1_spec_res   <= c1_spec_res;
      s1_spec_flags <= c1_spec_flags;
      s1_sign       <= a_big ? a_sign : b_sign;
      s1_eff_sub    <= a_sign ^ b_sign;
      s1_exp        <= a_big ? a_exp : b_exp;
      s1_diff       <= a_big ? (a_exp - b_exp) : (b_exp - a_exp);
      s1_man_l      <= a_big ? a_man : b_man;
      s1_man_s      <= a_big ? b_man : a_man;

      s2_tag        <= s1_tag;
      s2_spec       <= s1_spec;
      s2_spec_res   <= s1_spec_res;
      s2_spec_flags <= s1_spec_flags;
      s2_sign       <= s1_sign;
      s2_eff_sub    <= s1_eff_sub;
      s2_exp        <= s1_exp;
      s2_man_l      <= {s1_man_l, 3'b000};
      s2_man_s      <= c2_aligned;

      s3_tag        <= s2_tag;
      s3_spec       <= s2_spec;
      s3_spec_res   <= s2_spec_res;
      s3_spec_flags <= s2_spec_flags;
      s3_sign       <= s2_sign;
      s3_eff_sub    <= s2_eff_sub;
      s3_exp        <= s2_exp;
      s3_sum        <= c3_sum;
    end
  end

endmodule

// File: tb/tb_pipelined_fp_addsub.sv
// Directed self-checking bench for pipelined_fp_addsub (single and half precision).
module tb_pipelined_fp_addsub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, op = 1'b0, out_valid, out_ready = 1'b1;
  logic [31:0] a = '0, b = '0, result;
  logic [3:0]  tag_in = '0, tag_out;
  logic [2:0]  flags;

  logic        h_in_valid = 1'b0, h_in_ready, h_op = 1'b0, h_out_valid;
  logic [15:0] h_a = '0, h_b = '0, h_result;
  logic [3:0]  h_tag_in = '0, h_tag_out;
  logic [2:0]  h_flags;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    logic [2:0]  fl;
  } vec_t;

  always #5 clk = ~clk;

  pipelined_fp_addsub dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .tag_out(tag_out), .flags(flags)
  );

  pipelined_fp_addsub #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) h_dut (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .a(h_a), .b(h_b),
    .op(h_op), .tag_in(h_tag_in), .out_valid(h_out_valid), .out_ready(1'b1),
    .result(h_result), .tag_out(h_tag_out), .flags(h_flags)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Present one op to an idle pipe; lat counts edges from presentation to out_valid.
  task automatic run_op(input logic [31:0] va, input logic [31:0] vb, input logic vop,
                        input logic [3:0] vtag, output logic [31:0] r, output logic [3:0] t,
                        output logic [2:0] f, output int lat);
    a = va; b = vb; op = vop; tag_in = vtag; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result; t = tag_out; f = flags;
  endtask

  task automatic test_reset();
    a = 32'h3F800000; b = 32'h40000000; tag_in = 4'd7; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++;
    if (tag_out !== 4'h0 || flags !== 3'b000) begin
      errors++; $display("FAIL reset_tag_flags got %h/%b want 0/000", tag_out, flags);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    // Ops offered during reset must never emerge.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL reset_no_accept cycle %0d got out_valid %b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_vectors();
    vec_t vecs [20];
    logic [31:0] r;
    logic [3:0]  t;
    logic [2:0]  f;
    int          lat;
    vecs = '{
      '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000},  // 1+2
      '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000},  // exact cancel
      '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001},  // tie, stays even
      '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100},  // inf-inf
      '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011},  // overflow
      '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000},  // inf+finite
      '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000},  // 1-inf
      '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100},  // sNaN
      '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000},  // qNaN
      '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000},  // -0+-0
      '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 3'b000},  // +0+-0
      '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000},  // 3-1
      '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000},  // carry renorm
      '{32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 3'b000},  // massive cancel
      '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b001},  // above half, up
      '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000},  // subnormal in
      '{32'h80800001, 32'h80800000, 1'b1, 32'h80000000, 3'b001},  // flush, neg sign
      '{32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 3'b001},  // saturated shift
      '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001},  // tie, odd rounds up
      '{32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 3'b001}   // rounding carry-out
    };
    for (int i = 0; i < 20; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, 4'(i + 3), r, t, f, lat);
      checks++;
      if (r !== vecs[i].res) begin
        errors++; $display("FAIL vec%0d_result got %h want %h", i, r, vecs[i].res);
      end
      checks++;
      if (f !== vecs[i].fl) begin
        errors++; $display("FAIL vec%0d_flags got %b want %b", i, f, vecs[i].fl);
      end
      checks++;
      if (t !== 4'(i + 3)) begin
        errors++; $display("FAIL vec%0d_tag got %h want %h", i, t, 4'(i + 3));
      end
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL vec%0d_latency got %0d want 4", i, lat); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_tab [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic [31:0] e_tab [8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                               32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};
    int          sent = 0;
    int          got = 0;
    logic        rdy, ov;
    logic [31:0] r, snap_r;
    logic [3:0]  t, snap_t;
    for (int c = 0; c < 60 && got < 8; c++) begin
      out_ready = !(c >= 7 && c < 10);
      in_valid = (sent < 8);
      a = (sent < 8) ? a_tab[sent] : 32'h0;
      b = 32'h3F800000; op = 1'b0; tag_in = 4'(sent + 8);
      #1;
      rdy = in_ready; ov = out_valid; r = result; t = tag_out;
      if (c == 7) begin
        snap_r = r; snap_t = t;
      end
      if (c >= 7 && c < 10) begin
        checks++;
        if (rdy !== 1'b0 || ov !== 1'b1) begin
          errors++; $display("FAIL b2b_stall c%0d got in_ready %b out_valid %b want 0/1", c, rdy, ov);
        end
        checks++;
        if (r !== snap_r || t !== snap_t) begin
          errors++;
          $display("FAIL b2b_hold c%0d got %h/%h want %h/%h", c, r, t, snap_r, snap_t);
        end
      end
      @(posedge clk); #1;
      if (ov && out_ready) begin
        checks++;
        if (r !== e_tab[got] || t !== 4'(got + 8)) begin
          errors++;
          $display("FAIL b2b_out%0d got %h/%h want %h/%h", got, r, t, e_tab[got], 4'(got + 8));
        end
        got++;
      end
      if (in_valid && rdy) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got !== 8 || sent !== 8) begin
      errors++; $display("FAIL b2b_count got %0d/%0d want 8/8", got, sent);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL b2b_dup cycle %0d got out_valid %b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_reset_in_flight();
    logic [31:0] r;
    logic [3:0]  t;
    logic [2:0]  f;
    int          lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 32'h40000000; b = 32'h3F800000; op = 1'b0; tag_in = 4'(i + 1); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flight_reset got out_valid %b want 0", out_valid); end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL flight_discard cycle %0d got out_valid %b want 0", i, out_valid);
      end
    end
    run_op(32'h3F800000, 32'h40000000, 1'b0, 4'd5, r, t, f, lat);
    checks++;
    if (r !== 32'h40400000 || t !== 4'd5 || f !== 3'b000) begin
      errors++; $display("FAIL flight_next got %h/%h/%b want 40400000/5/000", r, t, f);
    end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL flight_latency got %0d want 4", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_half();
    logic [15:0] ha [3] = '{16'h3C00, 16'h4200, 16'h7BFF};
    logic [15:0] hb [3] = '{16'h4000, 16'h3C00, 16'h7BFF};
    logic        ho [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] hr [3] = '{16'h4200, 16'h4000, 16'h7C00};
    logic [2:0]  hf [3] = '{3'b000, 3'b000, 3'b011};
    int          lat;
    for (int i = 0; i < 3; i++) begin
      h_a = ha[i]; h_b = hb[i]; h_op = ho[i]; h_tag_in = 4'(i + 9); h_in_valid = 1'b1;
      @(posedge clk); #1;
      h_in_valid = 1'b0;
      lat = 1;
      while (!h_out_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      checks++;
      if (h_result !== hr[i] || h_flags !== hf[i] || h_tag_out !== 4'(i + 9)) begin
        errors++;
        $display("FAIL half%0d got %h/%b/%h want %h/%b/%h", i, h_result, h_flags, h_tag_out,
                 hr[i], hf[i], 4'(i + 9));
      end
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL half%0d_latency got %0d want 4", i, lat); end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_in_flight();
    test_half();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
